// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the counter sequencer.
// The load order lives here so the FSM and anything else that needs to
// know the register programming sequence agree on a single definition.
package counter_ctrl_pkg;

    // Sequencer states, in the order a normal run walks through them.
    typedef enum logic [3:0] {
        IDLE,
        LD_MAX,
        LD_MIN,
        LD_STEP,
        LD_START,
        SETTLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Number of counter registers programmed on each arm.
    localparam int LD_COUNT = 4;

    // Register programming order. START must stay last so the counter
    // output is loaded while MIN/MAX/STEP already hold the new values.
    localparam state_t LD_ORDER [LD_COUNT] = '{LD_MAX, LD_MIN, LD_STEP, LD_START};

    // Given one load state, return the state that follows it. The last
    // load state (and anything not in the table) hands over to SETTLE.
    function automatic state_t nextLoadState(input state_t s);
        state_t next;
        next = SETTLE;
        for (int i = 0; i < LD_COUNT - 1; i++) begin
            if (s == LD_ORDER[i]) begin
                next = LD_ORDER[i + 1];
            end
        end
        return next;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: every signal between the sequencer, the register bank
// and the counter it drives. The sequencer uses the master view; the
// register bank / counter side (or a bench) uses the slave view.
interface counter_ctrl_if;

    // Sequence control from the register bank.
    logic        arm_i;
    logic        disarm_i;

    // Configuration set, snapshotted on an accepted arm.
    logic [31:0] CFG_START;
    logic [31:0] CFG_STEP;
    logic [31:0] CFG_MAX;
    logic [31:0] CFG_MIN;
    logic        CFG_DIR;
    logic [31:0] NPULSES;
    logic [31:0] PERIOD;
    logic        STOP_ON_CARRY;

    // Feedback from the counter.
    logic        carry_i;

    // Counter register values and their write strobes.
    logic [31:0] START;
    logic [31:0] STEP;
    logic [31:0] MAX;
    logic [31:0] MIN;
    logic        START_WSTB;
    logic        STEP_WSTB;
    logic        MAX_WSTB;
    logic        MIN_WSTB;

    // Counter control inputs.
    logic        enable_o;
    logic        trigger_o;
    logic        dir_o;

    // Status back to the register bank.
    logic        active_o;
    logic        done_o;
    logic [31:0] pcount_o;
    logic        carry_seen_o;

    modport master (
        input  arm_i, disarm_i,
        input  CFG_START, CFG_STEP, CFG_MAX, CFG_MIN, CFG_DIR,
        input  NPULSES, PERIOD, STOP_ON_CARRY,
        input  carry_i,
        output START, STEP, MAX, MIN,
        output START_WSTB, STEP_WSTB, MAX_WSTB, MIN_WSTB,
        output enable_o, trigger_o, dir_o,
        output active_o, done_o, pcount_o, carry_seen_o
    );

    modport slave (
        output arm_i, disarm_i,
        output CFG_START, CFG_STEP, CFG_MAX, CFG_MIN, CFG_DIR,
        output NPULSES, PERIOD, STOP_ON_CARRY,
        output carry_i,
        input  START, STEP, MAX, MIN,
        input  START_WSTB, STEP_WSTB, MAX_WSTB, MIN_WSTB,
        input  enable_o, trigger_o, dir_o,
        input  active_o, done_o, pcount_o, carry_seen_o
    );

endinterface

// File: rtl/counter_ctrl_tick.sv
// counter_ctrl_tick: trigger period down-counter. A load reloads it to
// PERIOD-1 (a PERIOD of 0 behaves like 1); while enabled it counts down
// to zero and holds there. The tick is high whenever the count is zero.
module counter_ctrl_tick (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        i_load,
    input  logic        i_enable,
    input  logic [31:0] i_period,
    output logic        o_tick
);

    logic [31:0] r_count;
    logic [31:0] w_reload;

    // PERIOD of 0 and 1 both reload to 0, giving a tick every cycle.
    assign w_reload = (i_period == 32'd0) ? 32'd0 : (i_period - 32'd1);

    // Reload on each trigger, otherwise count down while the run is live.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= w_reload;
        end else if (i_enable && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_tick = (r_count == 32'd0);

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for the panda counter block. An arm snapshots
// the configuration, programs MAX/MIN/STEP/START with one strobe each,
// enables the counter and issues a programmed number of trigger pulses
// at a programmed period. Every output is a flop: each cycle the FSM
// works out what the current state wants to drive and that lands on the
// outputs at the next edge, so a disarm can silence them on that edge.
module counter_ctrl (
    input  logic           clk_i,
    input  logic           reset_n_i,
    counter_ctrl_if.master bus
);

    import counter_ctrl_pkg::*;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_snapStart;
    logic [31:0] r_snapStep;
    logic [31:0] r_snapMax;
    logic [31:0] r_snapMin;
    logic [31:0] r_snapNpulses;
    logic [31:0] r_snapPeriod;
    logic        r_snapDir;
    logic        r_snapStopOnCarry;

    logic [31:0] r_start;
    logic [31:0] r_step;
    logic [31:0] r_max;
    logic [31:0] r_min;
    logic [31:0] r_pcount;
    logic        r_startWstb;
    logic        r_stepWstb;
    logic        r_maxWstb;
    logic        r_minWstb;
    logic        r_enable;
    logic        r_trigger;
    logic        r_dir;
    logic        r_active;
    logic        r_done;
    logic        r_carrySeen;
    logic        r_firstRun;

    logic        w_startWstbNext;
    logic        w_stepWstbNext;
    logic        w_maxWstbNext;
    logic        w_minWstbNext;
    logic        w_enableNext;
    logic        w_triggerNext;
    logic        w_dirNext;
    logic        w_activeNext;
    logic        w_doneNext;
    logic        w_firstRunNext;
    logic        w_accept;
    logic        w_tick;
    logic        w_tickLoad;
    logic        w_tickEnable;
    logic        w_lastPulse;
    logic        w_carryStop;
    logic        w_carryWindow;
    logic [31:0] w_pcountInc;

    assign w_pcountInc   = r_pcount + 32'd1;
    assign w_lastPulse   = (r_snapNpulses != 32'd0) && (w_pcountInc == r_snapNpulses);
    assign w_carryStop   = r_snapStopOnCarry && bus.carry_i;
    assign w_carryWindow = (r_state == RUN) || (r_state == DRAIN);
    assign w_tickEnable  = (r_state == RUN);

    counter_ctrl_tick u_tick (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_load    (w_tickLoad),
        .i_enable  (w_tickEnable),
        .i_period  (r_snapPeriod),
        .o_tick    (w_tick)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and next output values for the current state; a disarm
    // outside IDLE overrides everything and silences the outputs.
    always_comb begin
        w_stateNext     = r_state;
        w_startWstbNext = 1'b0;
        w_stepWstbNext  = 1'b0;
        w_maxWstbNext   = 1'b0;
        w_minWstbNext   = 1'b0;
        w_enableNext    = 1'b0;
        w_triggerNext   = 1'b0;
        w_dirNext       = 1'b0;
        w_activeNext    = (r_state != IDLE);
        w_doneNext      = 1'b0;
        w_firstRunNext  = 1'b0;
        w_accept        = 1'b0;
        w_tickLoad      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.arm_i && !bus.disarm_i) begin
                    w_accept    = 1'b1;
                    w_stateNext = LD_ORDER[0];
                end
            end
            LD_MAX, LD_MIN, LD_STEP, LD_START: begin
                w_maxWstbNext   = (r_state == LD_MAX);
                w_minWstbNext   = (r_state == LD_MIN);
                w_stepWstbNext  = (r_state == LD_STEP);
                w_startWstbNext = (r_state == LD_START);
                w_stateNext     = nextLoadState(r_state);
            end
            SETTLE: begin
                w_enableNext   = 1'b1;
                w_dirNext      = r_snapDir;
                w_firstRunNext = 1'b1;
                w_stateNext    = RUN;
            end
            RUN: begin
                w_enableNext = 1'b1;
                w_dirNext    = r_snapDir;
                if (w_carryStop) begin
                    w_stateNext = DRAIN;
                end else if (r_firstRun || w_tick) begin
                    w_triggerNext = 1'b1;
                    w_tickLoad    = 1'b1;
                    if (w_lastPulse) begin
                        w_stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_enableNext = 1'b1;
                w_dirNext    = r_snapDir;
                w_stateNext  = DONE;
            end
            DONE: begin
                w_doneNext  = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if ((r_state != IDLE) && bus.disarm_i) begin
            w_stateNext     = IDLE;
            w_startWstbNext = 1'b0;
            w_stepWstbNext  = 1'b0;
            w_maxWstbNext   = 1'b0;
            w_minWstbNext   = 1'b0;
            w_enableNext    = 1'b0;
            w_triggerNext   = 1'b0;
            w_dirNext       = 1'b0;
            w_activeNext    = 1'b0;
            w_doneNext      = 1'b0;
            w_firstRunNext  = 1'b0;
            w_tickLoad      = 1'b0;
        end
    end

    // Configuration snapshot, taken only when an arm is accepted so that
    // register bank changes mid-run cannot disturb the sequence.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_snapStart       <= 32'd0;
            r_snapStep        <= 32'd0;
            r_snapMax         <= 32'd0;
            r_snapMin         <= 32'd0;
            r_snapNpulses     <= 32'd0;
            r_snapPeriod      <= 32'd0;
            r_snapDir         <= 1'b0;
            r_snapStopOnCarry <= 1'b0;
        end else if (w_accept) begin
            r_snapStart       <= bus.CFG_START;
            r_snapStep        <= bus.CFG_STEP;
            r_snapMax         <= bus.CFG_MAX;
            r_snapMin         <= bus.CFG_MIN;
            r_snapNpulses     <= bus.NPULSES;
            r_snapPeriod      <= bus.PERIOD;
            r_snapDir         <= bus.CFG_DIR;
            r_snapStopOnCarry <= bus.STOP_ON_CARRY;
        end
    end

    // Registered control outputs; register values only change on their
    // own strobe and otherwise keep the last programmed value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_startWstb <= 1'b0;
            r_stepWstb  <= 1'b0;
            r_maxWstb   <= 1'b0;
            r_minWstb   <= 1'b0;
            r_enable    <= 1'b0;
            r_trigger   <= 1'b0;
            r_dir       <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_firstRun  <= 1'b0;
            r_start     <= 32'd0;
            r_step      <= 32'd0;
            r_max       <= 32'd0;
            r_min       <= 32'd0;
        end else begin
            r_startWstb <= w_startWstbNext;
            r_stepWstb  <= w_stepWstbNext;
            r_maxWstb   <= w_maxWstbNext;
            r_minWstb   <= w_minWstbNext;
            r_enable    <= w_enableNext;
            r_trigger   <= w_triggerNext;
            r_dir       <= w_dirNext;
            r_active    <= w_activeNext;
            r_done      <= w_doneNext;
            r_firstRun  <= w_firstRunNext;
            if (w_maxWstbNext) begin
                r_max <= r_snapMax;
            end
            if (w_minWstbNext) begin
                r_min <= r_snapMin;
            end
            if (w_stepWstbNext) begin
                r_step <= r_snapStep;
            end
            if (w_startWstbNext) begin
                r_start <= r_snapStart;
            end
        end
    end

    // Pulse count and sticky carry flag, both cleared by an accepted arm.
    // The pulse count moves on the same edge as the trigger it counts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pcount    <= 32'd0;
            r_carrySeen <= 1'b0;
        end else if (w_accept) begin
            r_pcount    <= 32'd0;
            r_carrySeen <= 1'b0;
        end else begin
            if (w_triggerNext) begin
                r_pcount <= w_pcountInc;
            end
            if (w_carryWindow && bus.carry_i) begin
                r_carrySeen <= 1'b1;
            end
        end
    end

    assign bus.START        = r_start;
    assign bus.STEP         = r_step;
    assign bus.MAX          = r_max;
    assign bus.MIN          = r_min;
    assign bus.START_WSTB   = r_startWstb;
    assign bus.STEP_WSTB    = r_stepWstb;
    assign bus.MAX_WSTB     = r_maxWstb;
    assign bus.MIN_WSTB     = r_minWstb;
    assign bus.enable_o     = r_enable;
    assign bus.trigger_o    = r_trigger;
    assign bus.dir_o        = r_dir;
    assign bus.active_o     = r_active;
    assign bus.done_o       = r_done;
    assign bus.pcount_o     = r_pcount;
    assign bus.carry_seen_o = r_carrySeen;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: bench for the counter sequencer. Expected strobe,
// trigger and done events are queued when a run is armed and matched
// against what the sequencer drives; a small counter model closes the
// loop so carry_i comes from real counting.
module tb_counter_ctrl;

    localparam int K_MAX   = 1;
    localparam int K_MIN   = 2;
    localparam int K_STEP  = 3;
    localparam int K_START = 4;
    localparam int K_TRIG  = 5;
    localparam int K_DONE  = 6;

    typedef struct {
        int          kind;
        int          cycle;
        logic [31:0] value;
    } ev_t;

    typedef struct {
        logic [31:0] maxV;
        logic [31:0] minV;
        logic [31:0] stepV;
        logic [31:0] startV;
        logic [31:0] npulses;
        logic [31:0] period;
        logic        dir;
        logic        stopOnCarry;
    } cfg_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    int          cyc = 0;
    int          armCyc = 0;
    int          nChecks = 0;
    int          nFails = 0;
    ev_t         expQ[$];
    logic [31:0] modelOut = 32'd0;

    counter_ctrl_if bus ();

    counter_ctrl dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter used to time events relative to the arming edge.
    always @(posedge clk_i) begin
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushEvent(input int kind, input int cycle, input logic [31:0] value);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic observe(input int kind, input int n, input logic [31:0] value);
        ev_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedEventKind", kind, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", kind, e.kind);
            checkOutput("eventCycle", n, e.cycle);
            checkOutput("eventValue", value, e.value);
        end
    endtask

    function automatic cfg_t makeCfg(input logic [31:0] mx, input logic [31:0] mn,
                                     input logic [31:0] st, input logic [31:0] sv,
                                     input logic [31:0] np, input logic [31:0] pr,
                                     input logic d, input logic soc);
        cfg_t c;
        c.maxV = mx; c.minV = mn; c.stepV = st; c.startV = sv;
        c.npulses = np; c.period = pr; c.dir = d; c.stopOnCarry = soc;
        return c;
    endfunction

    // Drive a configuration, arm on one edge and queue what should follow:
    // the first nStrobes register writes, nTrig triggers, and a done pulse
    // at doneCycle when that is non-zero.
    task automatic applyStimulus(input cfg_t c, input int nStrobes, input int nTrig,
                                 input int doneCycle);
        logic [31:0] vals [4];
        int          peff;
        vals[0] = c.maxV; vals[1] = c.minV; vals[2] = c.stepV; vals[3] = c.startV;
        peff = (c.period == 32'd0) ? 1 : int'(c.period);
        @(negedge clk_i);
        bus.CFG_MAX = c.maxV; bus.CFG_MIN = c.minV;
        bus.CFG_STEP = c.stepV; bus.CFG_START = c.startV;
        bus.NPULSES = c.npulses; bus.PERIOD = c.period;
        bus.CFG_DIR = c.dir; bus.STOP_ON_CARRY = c.stopOnCarry;
        bus.arm_i = 1'b1;
        for (int k = 0; k < nStrobes; k++) pushEvent(K_MAX + k, k + 1, vals[k]);
        for (int k = 1; k <= nTrig; k++) pushEvent(K_TRIG, 6 + (k - 1) * peff, k);
        if (doneCycle > 0) pushEvent(K_DONE, doneCycle, nTrig);
        @(posedge clk_i);
        #1;
        armCyc = cyc;
        bus.arm_i = 1'b0;
    endtask

    task automatic waitToCycle(input int target);
        while ((cyc - armCyc) < target) @(negedge clk_i);
    endtask

    task automatic waitIdle(input int limit);
        for (int k = 0; k < limit && (expQ.size() != 0 || bus.active_o); k++) begin
            @(negedge clk_i);
        end
        if (expQ.size() != 0 || bus.active_o) checkOutput("idleTimeout", 1, 0);
        checkOutput("pendingEvents", expQ.size(), 0);
    endtask

    // Minimal counter: loads on START_WSTB, steps on enabled triggers,
    // wraps between MIN and MAX and raises carry for one cycle on a wrap.
    always @(negedge clk_i) begin
        logic [32:0] sum;
        if (!reset_n_i) begin
            modelOut    = 32'd0;
            bus.carry_i = 1'b0;
        end else begin
            bus.carry_i = 1'b0;
            if (bus.START_WSTB) begin
                modelOut = bus.START;
            end else if (bus.enable_o && bus.trigger_o) begin
                if (!bus.dir_o) begin
                    sum = {1'b0, modelOut} + {1'b0, bus.STEP};
                    if (sum > {1'b0, bus.MAX}) begin
                        modelOut    = bus.MIN;
                        bus.carry_i = 1'b1;
                    end else begin
                        modelOut = sum[31:0];
                    end
                end else begin
                    sum = {1'b0, bus.MIN} + {1'b0, bus.STEP};
                    if ({1'b0, modelOut} < sum) begin
                        modelOut    = bus.MAX;
                        bus.carry_i = 1'b1;
                    end else begin
                        modelOut = modelOut - bus.STEP;
                    end
                end
            end
        end
    end

    // Event monitor: every strobe, trigger and done pulse pops the queue.
    always @(negedge clk_i) begin
        int n;
        n = cyc - armCyc;
        if (reset_n_i) begin
            if (bus.MAX_WSTB)   observe(K_MAX, n, bus.MAX);
            if (bus.MIN_WSTB)   observe(K_MIN, n, bus.MIN);
            if (bus.STEP_WSTB)  observe(K_STEP, n, bus.STEP);
            if (bus.START_WSTB) observe(K_START, n, bus.START);
            if (bus.trigger_o)  observe(K_TRIG, n, bus.pcount_o);
            if (bus.done_o)     observe(K_DONE, n, bus.pcount_o);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfg_t s1;
        s1 = makeCfg(32'd10, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        bus.arm_i = 1'b0; bus.disarm_i = 1'b0;
        bus.CFG_MAX = 32'd0; bus.CFG_MIN = 32'd0; bus.CFG_STEP = 32'd0;
        bus.CFG_START = 32'd0; bus.NPULSES = 32'd0; bus.PERIOD = 32'd0;
        bus.CFG_DIR = 1'b0; bus.STOP_ON_CARRY = 1'b0;

        repeat (3) @(negedge clk_i);
        checkOutput("resetActive", bus.active_o, 0);
        checkOutput("resetEnable", bus.enable_o, 0);
        checkOutput("resetPcount", bus.pcount_o, 0);
        checkOutput("resetStart", bus.START, 0);
        reset_n_i = 1'b1;

        $display("[TB] basic run, period 4, three pulses");
        applyStimulus(s1, 4, 3, 16);
        waitIdle(60);
        checkOutput("s1Pcount", bus.pcount_o, 3);
        checkOutput("s1CounterOut", modelOut, 5);
        checkOutput("s1CarrySeen", bus.carry_seen_o, 0);

        $display("[TB] period 0, five back-to-back pulses, counting down");
        applyStimulus(makeCfg(32'd100, 32'd0, 32'd2, 32'd10, 32'd5, 32'd0, 1'b1, 1'b0),
                      4, 5, 12);
        waitToCycle(7);
        checkOutput("s2Dir", bus.dir_o, 1);
        checkOutput("s2Enable", bus.enable_o, 1);
        waitIdle(60);
        checkOutput("s2Pcount", bus.pcount_o, 5);
        checkOutput("s2CounterOut", modelOut, 0);

        $display("[TB] stop on carry, unlimited pulses");
        applyStimulus(makeCfg(32'd3, 32'd0, 32'd1, 32'd0, 32'd0, 32'd2, 1'b0, 1'b1),
                      4, 4, 15);
        waitIdle(60);
        checkOutput("s3CarrySeen", bus.carry_seen_o, 1);
        checkOutput("s3Pcount", bus.pcount_o, 4);

        $display("[TB] disarm mid-run");
        applyStimulus(s1, 4, 2, 0);
        waitToCycle(12);
        bus.disarm_i = 1'b1;
        @(negedge clk_i);
        bus.disarm_i = 1'b0;
        checkOutput("disarmEnable", bus.enable_o, 0);
        checkOutput("disarmActive", bus.active_o, 0);
        checkOutput("disarmPcount", bus.pcount_o, 2);
        checkOutput("disarmCarrySeen", bus.carry_seen_o, 0);
        repeat (8) @(negedge clk_i);
        checkOutput("disarmPending", expQ.size(), 0);
        checkOutput("disarmPcountHeld", bus.pcount_o, 2);

        $display("[TB] re-arm and config change during run");
        applyStimulus(s1, 4, 3, 16);
        waitToCycle(8);
        bus.arm_i = 1'b1;
        bus.CFG_STEP = 32'd7;
        @(negedge clk_i);
        bus.arm_i = 1'b0;
        waitIdle(60);
        checkOutput("rearmPcount", bus.pcount_o, 3);
        checkOutput("rearmCounterOut", modelOut, 5);
        checkOutput("rearmStepReg", bus.STEP, 1);

        $display("[TB] arm and disarm together in idle");
        @(negedge clk_i);
        bus.arm_i = 1'b1;
        bus.disarm_i = 1'b1;
        @(negedge clk_i);
        bus.arm_i = 1'b0;
        bus.disarm_i = 1'b0;
        repeat (6) @(negedge clk_i);
        checkOutput("armDisarmActive", bus.active_o, 0);
        checkOutput("armDisarmPcount", bus.pcount_o, 3);

        $display("[TB] reset during register load");
        applyStimulus(s1, 2, 0, 0);
        waitToCycle(2);
        #1;
        reset_n_i = 1'b0;
        #1;
        checkOutput("rstMinWstb", bus.MIN_WSTB, 0);
        checkOutput("rstActive", bus.active_o, 0);
        checkOutput("rstMax", bus.MAX, 0);
        checkOutput("rstMin", bus.MIN, 0);
        checkOutput("rstPending", expQ.size(), 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        checkOutput("rstPcount", bus.pcount_o, 0);
        applyStimulus(s1, 4, 3, 16);
        waitIdle(60);
        checkOutput("postRstPcount", bus.pcount_o, 3);
        checkOutput("postRstCounterOut", modelOut, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer for the panda `counter` block. On an arm pulse it snapshots a configuration set and programs the counter's MAX, MIN, STEP and START registers with one write strobe each. It then enables the counter and issues a programmed number of single-cycle trigger pulses at a programmed period. It stops on pulse count, on carry (optional) or on disarm. It sits between the register bank and the counter, and owns every counter input.

## Interface
- No parameters; all data widths are fixed at 32 bits.
- `clk_i  in  1  system clock`
- `reset_n_i  in  1  asynchronous, active-low reset`
- `arm_i  in  1  start-sequence pulse`
- `disarm_i  in  1  abort pulse`
- `CFG_START, CFG_STEP, CFG_MAX, CFG_MIN  in  32 each  values to program`
- `CFG_DIR  in  1  count direction driven on dir_o during run`
- `NPULSES  in  32  triggers to issue; 0 = unlimited`
- `PERIOD  in  32  cycles between trigger pulses; 0 is treated as 1`
- `STOP_ON_CARRY  in  1  end run on first carry_i`
- `carry_i  in  1  carry_o from the counter`
- `START, STEP, MAX, MIN  out  32 each  counter register values`
- `START_WSTB, STEP_WSTB, MAX_WSTB, MIN_WSTB  out  1 each  write strobes`
- `enable_o, trigger_o, dir_o  out  1 each  counter control inputs`
- `active_o  out  1  high in every state except IDLE`
- `done_o  out  1  one-cycle pulse on normal completion`
- `pcount_o  out  32  triggers issued in the current or last run`
- `carry_seen_o  out  1  sticky; set by carry_i during RUN`

## Operation
- FSM states: IDLE, LD_MAX, LD_MIN, LD_STEP, LD_START, SETTLE, RUN, DRAIN, DONE.
- **IDLE.** An `arm_i` pulse snapshots all CFG_*, NPULSES, PERIOD and STOP_ON_CARRY, clears `pcount_o` and `carry_seen_o`, and moves to LD_MAX. `arm_i` in any other state is ignored.
- **Load states.** Each LD_x state lasts one cycle. It drives x = snapshot value and x_WSTB = 1; the other strobes are 0. START is written last so the counter output loads with MIN/MAX/STEP already valid.
- **SETTLE.** Lasts one cycle. `enable_o` = 1 and `dir_o` = snapshot DIR; no trigger.
- **RUN.** `enable_o` = 1.
  - `trigger_o` pulses on the first RUN cycle, then every PERIOD cycles.
  - `pcount_o` increments in the same cycle as each trigger.
  - Exit to DRAIN on the cycle after the trigger that makes `pcount_o` == NPULSES (NPULSES ≠ 0).
  - With STOP_ON_CARRY = 1, also exit to DRAIN on the cycle after `carry_i` = 1. Carry takes priority over the period tick in that cycle: no further trigger.
- **DRAIN.** Lasts one cycle. `enable_o` = 1 and no trigger, so the last count settles.
- **DONE.** Lasts one cycle. `enable_o` = 0 and `done_o` = 1; then go to IDLE.
- **Disarm.** `disarm_i` in any non-IDLE state goes to IDLE on the next edge. `enable_o`, `trigger_o` and all strobes are 0 from that cycle on, with no `done_o`. `disarm_i` and `arm_i` in the same IDLE cycle: the arm is ignored.
- **Config changes.** CFG_* changes during a run have no effect until the next arm.
- **Carry flag.** `carry_seen_o` is set by `carry_i` in RUN or DRAIN and held until the next accepted arm.

## Timing
- All outputs are registered. Reset values: all outputs 0, state IDLE.
- Assertion during reset mid-run deasserts every output immediately (asynchronous). Deassertion is synchronised by the reset-release logic upstream.
- Cycle N = Nth rising edge after the edge that samples `arm_i`:
  - N = 1: MAX_WSTB
  - N = 2: MIN_WSTB
  - N = 3: STEP_WSTB
  - N = 4: START_WSTB
  - N = 5: SETTLE (`enable_o` rises)
  - N = 6: first `trigger_o`
  - Trigger k occurs at 6 + (k−1)·PERIOD.
- Normal completion with NPULSES = n: DRAIN at 7 + (n−1)·PERIOD, `done_o` one cycle later, IDLE after that.
- **Period counter.** 32-bit, reloads to PERIOD−1 on each trigger and counts down. PERIOD = 1 gives a trigger every RUN cycle.
- **Pulse count.** `pcount_o` is 32 bits and wraps silently in unlimited mode.

## Structure
- Package `counter_ctrl_pkg` holds the state enumeration and a constant for the LD_* order.
- One sub-module, `counter_ctrl_tick`, is natural: the period down-counter. It takes load, enable and PERIOD and produces a tick. The FSM stays in `counter_ctrl`.

## Test plan
- MAX=10, MIN=0, STEP=1, START=2, NPULSES=3, PERIOD=4, arm at N=0 -> strobes at N=1..4 in order MAX/MIN/STEP/START; triggers at N=6, 10, 14; `done_o` at N=16; counter out = 5.
- PERIOD=0, NPULSES=5 -> triggers on 5 consecutive cycles from N=6; `pcount_o`=5.
- MAX=3, START=0, STEP=1, STOP_ON_CARRY=1, NPULSES=0, PERIOD=2 -> counter carries; next cycle DRAIN, no further trigger, `carry_seen_o`=1, `done_o` pulses.
- Disarm in cycle 12 of the first scenario -> `enable_o` 0 from cycle 13, no `done_o`, `pcount_o` holds 2.
- Arm during RUN and change CFG_STEP mid-run -> no re-load strobes, triggers unchanged; simultaneous arm+disarm in IDLE -> stays IDLE.
- `reset_n_i` low during LD_STEP -> all outputs 0 in the same cycle; next arm restarts at LD_MAX.
